// File: rtl/da_ctrl_if.sv
// -----------------------------------------------------------------------------
// da_ctrl_if
//   Bundles every non-clock signal of the da_ctrl sequencer: the coefficient
//   stream, the sample stream, the result port and the control pins of the
//   distributed-arithmetic core `da`.
//
//   Modports:
//     slave  - the view of da_ctrl itself (drives ready/result/da_* pins).
//     master - the view of its surroundings (sources, sink and the da core).
//
//   Signals (direction as seen by da_ctrl):
//     cfg_reload  in   pulse, restart ROM load
//     coef_valid  in   / coef_ready out / coef_data in [COEF_W]
//     smp_valid   in   / smp_ready  out / smp_data  in [64] {A7..A0}
//     res_valid   out  / res_ready  in  / res_data  out [ACC_W]
//     da_caddr, da_cin, da_cload, da_valid_in, da_start, da_clr, da_a  out
//     da_acc, da_done  in
//     rom_loaded, err  out
// -----------------------------------------------------------------------------
interface da_ctrl_if #(
  parameter int COEF_W = 20,
  parameter int ACC_W  = 39,
  parameter int ADDR_W = 11
);
  logic              cfg_reload;
  logic              coef_valid;
  logic              coef_ready;
  logic [COEF_W-1:0] coef_data;
  logic              smp_valid;
  logic              smp_ready;
  logic [63:0]       smp_data;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic [ADDR_W-1:0] da_caddr;
  logic [COEF_W-1:0] da_cin;
  logic              da_cload;
  logic              da_valid_in;
  logic              da_start;
  logic              da_clr;
  logic [63:0]       da_a;
  logic [ACC_W-1:0]  da_acc;
  logic              da_done;
  logic              rom_loaded;
  logic              err;

  modport slave (
    input  cfg_reload, coef_valid, coef_data, smp_valid, smp_data, res_ready,
           da_acc, da_done,
    output coef_ready, smp_ready, res_valid, res_data, da_caddr, da_cin,
           da_cload, da_valid_in, da_start, da_clr, da_a, rom_loaded, err
  );

  modport master (
    output cfg_reload, coef_valid, coef_data, smp_valid, smp_data, res_ready,
           da_acc, da_done,
    input  coef_ready, smp_ready, res_valid, res_data, da_caddr, da_cin,
           da_cload, da_valid_in, da_start, da_clr, da_a, rom_loaded, err
  );
endinterface

// File: rtl/da_ctrl.sv
// -----------------------------------------------------------------------------
// da_ctrl
//   Sequencer for the distributed-arithmetic FIR core `da`. First streams
//   ROM_WORDS precomputed ROM words into the core, then runs ITERS-iteration
//   accumulation frames driven by a valid/ready sample stream, and presents
//   the final accumulator on a backpressured result port. A watchdog aborts
//   an iteration whose da_done does not arrive within TIMEOUT cycles.
//
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  asynchronous, active-high; clears all state
//     bus    da_ctrl_if.slave - streams, result port and da core pins
// -----------------------------------------------------------------------------
module da_ctrl #(
  parameter int ROM_WORDS = 2048,
  parameter int ITERS     = 16,
  parameter int COEF_W    = 20,
  parameter int ACC_W     = 39,
  parameter int TIMEOUT   = 64
) (
  input  logic     clk,
  input  logic     reset,
  da_ctrl_if.slave bus
);

  localparam int ADDR_W = $clog2(ROM_WORDS);
  localparam int ITER_W = $clog2(ITERS);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_WORDS - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERS - 1);
  localparam logic [TMR_W-1:0]  LAST_TMR  = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    LOAD,
    READY,
    RUN,
    OUT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ITER_W-1:0] iter;
  logic [TMR_W-1:0]  timer;

  // Ready outputs are registered and only ever high in their own state, so
  // these handshakes cannot fire in any other state.
  logic coef_fire;
  logic smp_fire;
  assign coef_fire = bus.coef_valid & bus.coef_ready;
  assign smp_fire  = bus.smp_valid  & bus.smp_ready;

  // NOTE: all state and outputs are updated with non-blocking assignments so
  // every branch below sees the values from before this clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= LOAD;
      addr            <= '0;
      iter            <= '0;
      timer           <= '0;
      bus.coef_ready  <= 1'b0;
      bus.smp_ready   <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.da_caddr    <= '0;
      bus.da_cin      <= '0;
      bus.da_cload    <= 1'b0;
      bus.da_valid_in <= 1'b0;
      bus.da_start    <= 1'b0;
      bus.da_clr      <= 1'b0;
      bus.da_a        <= '0;
      bus.rom_loaded  <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      // NOTE: single-cycle strobes default low here; the state branches only
      // raise them, which keeps each pulse exactly one cycle wide.
      bus.da_cload    <= 1'b0;
      bus.da_valid_in <= 1'b0;
      bus.da_start    <= 1'b0;
      bus.da_clr      <= 1'b0;

      unique case (state)
        LOAD: begin
          bus.coef_ready <= 1'b1;
          if (bus.cfg_reload) begin
            // Restart from the top; a beat arriving with the reload belongs
            // to the abandoned stream and is dropped.
            addr <= '0;
          end else if (coef_fire) begin
            bus.da_caddr    <= addr;
            bus.da_cin      <= bus.coef_data;
            bus.da_cload    <= 1'b1;
            bus.da_valid_in <= 1'b1;
            if (addr == LAST_ADDR) begin
              bus.rom_loaded <= 1'b1;
              bus.coef_ready <= 1'b0;
              bus.smp_ready  <= 1'b1;
              state          <= READY;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end

        READY: begin
          // Reload takes priority over a simultaneous sample.
          if (bus.cfg_reload) begin
            bus.rom_loaded <= 1'b0;
            bus.smp_ready  <= 1'b0;
            bus.coef_ready <= 1'b1;
            addr           <= '0;
            iter           <= '0;
            state          <= LOAD;
          end else if (smp_fire) begin
            bus.da_a      <= bus.smp_data;
            bus.da_start  <= 1'b1;
            bus.da_clr    <= (iter == '0);
            bus.smp_ready <= 1'b0;
            timer         <= '0;
            state         <= RUN;
          end
        end

        RUN: begin
          // timer equals the number of cycles elapsed since the da_start cycle.
          if (bus.da_done) begin
            if (iter == LAST_ITER) begin
              bus.res_data  <= bus.da_acc;
              bus.res_valid <= 1'b1;
              iter          <= '0;
              state         <= OUT;
            end else begin
              iter          <= iter + 1'b1;
              bus.smp_ready <= 1'b1;
              state         <= READY;
            end
          end else if (timer == LAST_TMR) begin
            bus.err       <= 1'b1;
            bus.smp_ready <= 1'b1;
            iter          <= '0;
            state         <= READY;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        OUT: begin
          if (bus.res_valid && bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.smp_ready <= 1'b1;
            state         <= READY;
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_da_ctrl.sv
// -----------------------------------------------------------------------------
// tb_da_ctrl
//   Directed bench for da_ctrl. The da core is modelled by driving da_done and
//   da_acc from the stimulus sequence. Inputs change 1 time unit after the
//   rising edge, outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_da_ctrl;

  localparam int COEF_W = 20;
  localparam int ACC_W  = 39;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_clr    = 0;

  da_ctrl_if #(.COEF_W(COEF_W), .ACC_W(ACC_W)) bus ();

  da_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one cycle and tally strobes seen in the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.da_start) n_start++;
    if (bus.da_clr)   n_clr++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"},
          64'({bus.coef_ready, bus.smp_ready, bus.res_valid, bus.rom_loaded,
               bus.err, bus.da_cload, bus.da_valid_in, bus.da_start,
               bus.da_clr}), 64'd0);
    check({tag, "_caddr"},    64'(bus.da_caddr), 64'd0);
    check({tag, "_cin"},      64'(bus.da_cin),   64'd0);
    check({tag, "_da_a"},     64'(bus.da_a),     64'd0);
    check({tag, "_res_data"}, 64'(bus.res_data), 64'd0);
  endtask

  // Offer one sample while smp_ready is high; ends in the da_start cycle.
  task automatic send_sample(input string tag, input logic [63:0] d,
                             input logic exp_clr);
    bus.smp_valid = 1'b1;
    bus.smp_data  = d;
    step();
    bus.smp_valid = 1'b0;
    check({tag, "_start"},     64'(bus.da_start),  64'd1);
    check({tag, "_clr"},       64'(bus.da_clr),    64'(exp_clr));
    check({tag, "_da_a"},      bus.da_a,           d);
    check({tag, "_smp_ready"}, 64'(bus.smp_ready), 64'd0);
  endtask

  // From the da_start cycle S, raise da_done for one cycle at S+n.
  task automatic done_after(input int n, input logic [ACC_W-1:0] acc);
    repeat (n) step();
    bus.da_done = 1'b1;
    bus.da_acc  = acc;
    step();
    bus.da_done = 1'b0;
  endtask

  initial begin
    logic [COEF_W-1:0] d;
    logic [63:0]       pat;

    reset          = 1'b1;
    bus.cfg_reload = 1'b0;
    bus.coef_valid = 1'b0;
    bus.coef_data  = '0;
    bus.smp_valid  = 1'b0;
    bus.smp_data   = '0;
    bus.res_ready  = 1'b0;
    bus.da_acc     = '0;
    bus.da_done    = 1'b0;

    // ---- reset state ----
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;
    step();
    check("post_reset_coef_ready", 64'(bus.coef_ready), 64'd1);
    check("post_reset_smp_ready",  64'(bus.smp_ready),  64'd0);

    // ---- full ROM load, coef_data = addr - 1024, one idle gap ----
    for (int i = 0; i < 2048; i++) begin
      if (i == 5) begin
        bus.coef_valid = 1'b0;
        step();
        check("gap_cload", 64'({bus.da_cload, bus.da_valid_in}), 64'd0);
        check("gap_caddr_hold", 64'(bus.da_caddr), 64'd4);
      end
      d              = COEF_W'(i - 1024);
      bus.coef_valid = 1'b1;
      bus.coef_data  = d;
      step();
      check("load_beat",
            64'({bus.da_caddr, bus.da_cin, bus.da_cload, bus.da_valid_in}),
            64'({11'(i), d, 2'b11}));
      if (i < 2047)
        check("load_rom_loaded_low", 64'(bus.rom_loaded), 64'd0);
    end
    bus.coef_valid = 1'b0;
    check("rom_loaded",      64'(bus.rom_loaded), 64'd1);
    check("coef_ready_drop", 64'(bus.coef_ready), 64'd0);
    check("smp_ready_up",    64'(bus.smp_ready),  64'd1);

    // ---- 16-iteration frame, done 11 cycles after each start ----
    n_start = 0;
    n_clr   = 0;
    for (int k = 0; k < 16; k++) begin
      pat = 64'h0102_0304_0506_0700 + 64'(k);
      send_sample("frame", pat, k == 0);
      done_after(11, (k == 15) ? 39'h00_0000_1234 : 39'h7F_0000_0077);
      if (k < 15) begin
        check("frame_iter_smp_ready", 64'(bus.smp_ready), 64'd1);
        check("frame_iter_res_valid", 64'(bus.res_valid), 64'd0);
      end
    end
    check("frame_res_valid", 64'(bus.res_valid), 64'd1);
    check("frame_res_data",  64'(bus.res_data),  64'h1234);
    check("frame_smp_ready", 64'(bus.smp_ready), 64'd0);
    check("frame_starts",    64'(n_start),       64'd16);
    check("frame_clrs",      64'(n_clr),         64'd1);

    // ---- result backpressure for 20 cycles ----
    n_start       = 0;
    bus.smp_valid = 1'b1;
    bus.da_acc    = 39'h55;
    for (int c = 0; c < 20; c++) begin
      step();
      check("hold_res_valid", 64'(bus.res_valid), 64'd1);
      check("hold_res_data",  64'(bus.res_data),  64'h1234);
      check("hold_smp_ready", 64'(bus.smp_ready), 64'd0);
    end
    bus.smp_valid = 1'b0;
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("release_res_valid", 64'(bus.res_valid), 64'd0);
    check("release_smp_ready", 64'(bus.smp_ready), 64'd1);
    check("hold_no_start",     64'(n_start),       64'd0);

    // ---- timeout: one good iteration, then da_done never comes ----
    send_sample("to_a", 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
    done_after(3, 39'h9);
    check("to_a_smp_ready", 64'(bus.smp_ready), 64'd1);
    send_sample("to_b", 64'hBBBB_BBBB_BBBB_BBBB, 1'b0);
    repeat (63) step();
    check("to_err_early", 64'(bus.err), 64'd0);
    step();
    check("to_err",       64'(bus.err),       64'd1);
    check("to_smp_ready", 64'(bus.smp_ready), 64'd1);
    check("to_res_valid", 64'(bus.res_valid), 64'd0);

    // ---- da_done outside RUN is ignored ----
    n_start     = 0;
    bus.da_done = 1'b1;
    step();
    bus.da_done = 1'b0;
    check("stray_done_res_valid", 64'(bus.res_valid), 64'd0);
    check("stray_done_smp_ready", 64'(bus.smp_ready), 64'd1);
    check("stray_done_no_start",  64'(n_start),       64'd0);

    // ---- after timeout the next sample restarts the frame ----
    send_sample("to_c", 64'hCCCC_CCCC_CCCC_CCCC, 1'b1);
    done_after(2, 39'h1);
    check("to_c_smp_ready", 64'(bus.smp_ready), 64'd1);
    check("err_sticky",     64'(bus.err),       64'd1);

    // ---- cfg_reload together with smp_valid in READY ----
    bus.cfg_reload = 1'b1;
    bus.smp_valid  = 1'b1;
    step();
    bus.cfg_reload = 1'b0;
    bus.smp_valid  = 1'b0;
    check("reload_no_start",   64'(bus.da_start),   64'd0);
    check("reload_rom_loaded", 64'(bus.rom_loaded), 64'd0);
    check("reload_smp_ready",  64'(bus.smp_ready),  64'd0);
    check("reload_coef_ready", 64'(bus.coef_ready), 64'd1);
    check("reload_da_a_hold",  bus.da_a, 64'hCCCC_CCCC_CCCC_CCCC);

    // ---- 1000 beats of the new load, then reset mid-load ----
    for (int i = 0; i < 1000; i++) begin
      d              = COEF_W'(i + 7);
      bus.coef_valid = 1'b1;
      bus.coef_data  = d;
      step();
      check("reload_beat",
            64'({bus.da_caddr, bus.da_cin, bus.da_cload}),
            64'({11'(i), d, 1'b1}));
    end
    bus.coef_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    reset = 1'b0;
    step();
    check("midreset_coef_ready", 64'(bus.coef_ready), 64'd1);
    d              = COEF_W'(-3);
    bus.coef_valid = 1'b1;
    bus.coef_data  = d;
    step();
    bus.coef_valid = 1'b0;
    check("midreset_first_beat",
          64'({bus.da_caddr, bus.da_cin, bus.da_cload}),
          64'({11'd0, d, 1'b1}));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
